// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART receive front end: receiver
//               FSM state encoding, frame data width and the default bit
//               period.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Data bits per 8N1 frame (start and stop bits are handled by the FSM)
  localparam int DATA_BITS = 8;

  // Default bit period: 50 MHz core clock at 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO built from a register array.
//               Pointers carry one extra wrap bit so that full and empty can
//               be told apart without a separate counter.
// Ports       : clk   - clock, rising edge
//               rst_n - synchronous active-low reset (clears pointers)
//               push  - write din this edge (dropped when full unless a pop
//                       happens in the same cycle)
//               din   - write data
//               pop   - advance the read pointer (ignored when empty)
//               dout  - head entry, zero when empty
//               empty - no entry held
//               full  - DEPTH entries held
//               level - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wp_q, wp_d;
  logic [DEPTH_LOG2:0] rp_q, rp_d;
  logic                w_pop_ok;
  logic                w_push_ok;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2]) &&
                 (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0]);
  assign level = wp_q - rp_q;

  // A pop only counts when there is something to pop. A push into a full
  // FIFO is still accepted when the head leaves in the same cycle: the slot
  // being written is exactly the one being vacated.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  assign dout = empty ? '0 : mem_q[rp_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (w_push_ok) wp_d = wp_q + 1'b1;
    if (w_pop_ok)  rp_d = rp_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage needs no reset: dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wp_q[DEPTH_LOG2-1:0]] <= din;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive front end. Synchronises the async 8N1 serial
//               line, deserialises LSB-first bytes and queues them in a
//               show-ahead FIFO read by the core's UART load path.
// Ports       : clk        - core clock, rising edge
//               rst_n      - synchronous active-low reset
//               rxd        - asynchronous serial line, idle high
//               uart_empty - FIFO holds no byte
//               uart_in    - head byte, 8'h00 when empty
//               uart_rdreq - pop head at this edge (ignored when empty)
//               uart_level - FIFO occupancy, 0..DEPTH
//               overrun    - pulse: good byte dropped, FIFO full
//               frame_err  - pulse: stop bit low, byte discarded
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rxd,
  output logic                  uart_empty,
  output logic [DATA_BITS-1:0]  uart_in,
  input  logic                  uart_rdreq,
  output logic [DEPTH_LOG2:0]   uart_level,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  // Two-flop synchroniser; both flops idle high so reset cannot fake a start
  logic sync1_q;
  logic rxs_q;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push_req;

  logic                 fifo_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = ST_START;
      end

      // Re-check the line half a bit in; a high level means a glitch
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // LSB arrives first, so shift in from the top
      ST_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rxs_q) begin
            push_req = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Wait out a held-low line so it cannot look like a stream of starts
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A byte is lost only when the FIFO is full and no pop frees a slot now
  assign overrun_d = push_req && fifo_full && !(uart_rdreq && !uart_empty);

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

  sync_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (shreg_q),
    .pop   (uart_rdreq),
    .dout  (uart_in),
    .empty (uart_empty),
    .full  (fifo_full),
    .level (uart_level)
  );

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo with a 4-clock
//               bit period and a 4-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB  = 4;
  localparam int DL2  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rxd = 1'b1;
  logic           uart_empty;
  logic [7:0]     uart_in;
  logic           uart_rdreq = 1'b0;
  logic [DL2:0]   uart_level;
  logic           overrun;
  logic           frame_err;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int fe_cnt = 0;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH_LOG2   (DL2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .uart_empty (uart_empty),
    .uart_in    (uart_in),
    .uart_rdreq (uart_rdreq),
    .uart_level (uart_level),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (overrun)   ov_cnt++;
    if (frame_err) fe_cnt++;
  end

  // Called 1 time unit after a rising edge; returns 1 unit after the 40th
  // edge of the frame, one edge before the receiver samples the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
  endtask

  task automatic do_pop();
    uart_rdreq = 1'b1;
    @(posedge clk); #1;
    uart_rdreq = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if ({uart_empty, uart_in, uart_level, overrun, frame_err} !== {1'b1, 8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: empty=%b in=%h level=%0d ov=%b fe=%b, want 1 00 0 0 0",
               uart_empty, uart_in, uart_level, overrun, frame_err);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    send_byte(8'hA5, 1'b1);
    checks++;
    if (uart_empty !== 1'b1) begin
      errors++; $display("FAIL single_pre_push: empty=%b want 1", uart_empty);
    end
    idle(1);
    checks++;
    if ({uart_empty, uart_in, uart_level} !== {1'b0, 8'hA5, 3'd1}) begin
      errors++;
      $display("FAIL single_latency: empty=%b in=%h level=%0d want 0 a5 1", uart_empty, uart_in, uart_level);
    end
    do_pop();
    checks++;
    if ({uart_empty, uart_in, uart_level} !== {1'b1, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL single_pop: empty=%b in=%h level=%0d want 1 00 0", uart_empty, uart_in, uart_level);
    end
    do_pop();
    checks++;
    if ({uart_empty, uart_level} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL pop_empty: empty=%b level=%0d want 1 0", uart_empty, uart_level);
    end
    // Push and pop at the same edge on an empty FIFO: push wins
    send_byte(8'h5A, 1'b1);
    do_pop();
    checks++;
    if ({uart_empty, uart_in, uart_level} !== {1'b0, 8'h5A, 3'd1}) begin
      errors++;
      $display("FAIL push_pop_empty: empty=%b in=%h level=%0d want 0 5a 1", uart_empty, uart_in, uart_level);
    end
    do_pop();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 3; k++) send_byte(8'(k), 1'b1);
      idle(2);
      checks++;
      if (uart_level !== 3'd3) begin
        errors++; $display("FAIL b2b_level round %0d: level=%0d want 3", r, uart_level);
      end
      for (int k = 1; k <= 3; k++) begin
        exp = 8'(k);
        checks++;
        if (uart_in !== exp) begin
          errors++; $display("FAIL b2b_order round %0d: in=%h want %h", r, uart_in, exp);
        end
        do_pop();
      end
      checks++;
      if ({uart_empty, uart_in} !== {1'b1, 8'h00}) begin
        errors++; $display("FAIL b2b_drain round %0d: empty=%b in=%h want 1 00", r, uart_empty, uart_in);
      end
    end
  endtask

  task automatic test_overrun();
    int ov0;
    logic [7:0] exp;
    ov0 = ov_cnt;
    for (int k = 0; k < 5; k++) send_byte(8'h10 + 8'(k), 1'b1);
    idle(3);
    checks++;
    if (ov_cnt - ov0 !== 1) begin
      errors++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt - ov0);
    end
    checks++;
    if (uart_level !== 3'd4) begin
      errors++; $display("FAIL overrun_level: level=%0d want 4", uart_level);
    end
    for (int k = 0; k < 4; k++) begin
      exp = 8'h10 + 8'(k);
      checks++;
      if (uart_in !== exp) begin
        errors++; $display("FAIL overrun_data: in=%h want %h", uart_in, exp);
      end
      do_pop();
    end
    checks++;
    if (uart_empty !== 1'b1) begin
      errors++; $display("FAIL overrun_drain: empty=%b want 1", uart_empty);
    end
  endtask

  task automatic test_full_pop();
    int ov0;
    logic [7:0] exp;
    ov0 = ov_cnt;
    for (int k = 0; k < 4; k++) send_byte(8'h21 + 8'(k), 1'b1);
    send_byte(8'h25, 1'b1);
    do_pop();
    idle(1);
    checks++;
    if (ov_cnt - ov0 !== 0) begin
      errors++; $display("FAIL full_pop_overrun: got %0d pulses want 0", ov_cnt - ov0);
    end
    checks++;
    if ({uart_level, uart_in} !== {3'd4, 8'h22}) begin
      errors++; $display("FAIL full_pop_state: level=%0d in=%h want 4 22", uart_level, uart_in);
    end
    for (int k = 0; k < 4; k++) begin
      exp = 8'h22 + 8'(k);
      checks++;
      if (uart_in !== exp) begin
        errors++; $display("FAIL full_pop_data: in=%h want %h", uart_in, exp);
      end
      do_pop();
    end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h3C, 1'b0);
    rxd = 1'b0;
    idle(20);
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      errors++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt - fe0);
    end
    rxd = 1'b1;
    idle(8);
    checks++;
    if ({uart_empty, uart_level, fe_cnt - fe0} !== {1'b1, 3'd0, 32'd1}) begin
      errors++;
      $display("FAIL frame_err_nopush: empty=%b level=%0d fe=%0d want 1 0 1", uart_empty, uart_level, fe_cnt - fe0);
    end
    send_byte(8'h55, 1'b1);
    idle(2);
    checks++;
    if ({uart_empty, uart_in, uart_level} !== {1'b0, 8'h55, 3'd1}) begin
      errors++;
      $display("FAIL frame_err_recover: empty=%b in=%h level=%0d want 0 55 1", uart_empty, uart_in, uart_level);
    end
    do_pop();
  endtask

  task automatic test_glitch_reset();
    logic [9:0] frame;
    int ov0, fe0;
    ov0 = ov_cnt; fe0 = fe_cnt;
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    idle(20);
    checks++;
    if ({uart_empty, uart_level, fe_cnt - fe0} !== {1'b1, 3'd0, 32'd0}) begin
      errors++;
      $display("FAIL glitch: empty=%b level=%0d fe=%0d want 1 0 0", uart_empty, uart_level, fe_cnt - fe0);
    end
    // Leave one byte queued so the reset has something visible to clear
    send_byte(8'h33, 1'b1);
    idle(2);
    frame = {1'b1, 8'h96, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd = frame[i];
      idle(CPB);
    end
    rxd = frame[5];
    idle(2);
    rst_n = 1'b0;
    rxd   = 1'b1;
    idle(1);
    checks++;
    if ({uart_empty, uart_in, uart_level, overrun, frame_err} !== {1'b1, 8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset: empty=%b in=%h level=%0d ov=%b fe=%b want 1 00 0 0 0",
               uart_empty, uart_in, uart_level, overrun, frame_err);
    end
    idle(1);
    rst_n = 1'b1;
    idle(60);
    checks++;
    if ({uart_empty, uart_level, ov_cnt - ov0, fe_cnt - fe0} !== {1'b1, 3'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL post_reset_quiet: empty=%b level=%0d ov=%0d fe=%0d want 1 0 0 0",
               uart_empty, uart_level, ov_cnt - ov0, fe_cnt - fe0);
    end
    send_byte(8'h7E, 1'b1);
    idle(2);
    checks++;
    if ({uart_empty, uart_in, uart_level} !== {1'b0, 8'h7E, 3'd1}) begin
      errors++;
      $display("FAIL post_reset_rx: empty=%b in=%h level=%0d want 0 7e 1", uart_empty, uart_in, uart_level);
    end
    do_pop();
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_full_pop();
    test_frame_err();
    test_glitch_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo
`default_nettype wire
